icache_refill_module: RTL and testbench

Memory-side responder for instruction-cache line refills. It accepts the level-sensitive miss request from the icache top, issues one burst read per 64-byte line to the memory bus, and assembles eight 64-bit beats into a 512-bit line. It returns the line to the icache as a single-cycle valid pulse. It sits between the icache top and the bus/L2 port and honours frontend flushes by discarding in-flight fills.

---
 rtl/icache_refill_module.sv | 96 +++++++++
 tb/tb_icache_refill_module.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_module.sv
// Instruction-cache refill engine: one burst read per 64-byte line, eight beats
// assembled into a 512-bit line and returned to the icache as a one-cycle pulse.
module icache_refill_module #(
    parameter int BEAT_WIDTH  = 64,
    parameter int PADDR_WIDTH = 34
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_icache_mem_vld,
    input  logic [PADDR_WIDTH-1:0]  i_icache_mem_paddr,
    input  logic                    i_refill_flush,
    output logic                    o_refill_bus_req,
    output logic [PADDR_WIDTH-1:0]  o_refill_bus_addr,
    input  logic                    i_bus_refill_ack,
    input  logic                    i_bus_refill_rvld,
    input  logic [BEAT_WIDTH-1:0]   i_bus_refill_rdat,
    output logic                    o_mem_icache_vld,
    output logic [8*BEAT_WIDTH-1:0] o_mem_icache_data,
    output logic [PADDR_WIDTH-1:0]  o_mem_icache_paddr,
    output logic                    o_refill_busy,
    output logic [2:0]              dbg_state
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] RESP = 3'd3;
    localparam logic [2:0] COOL = 3'd4;

    logic [2:0]              state;
    logic [2:0]              cnt;
    logic                    drop_q;
    logic [PADDR_WIDTH-1:0]  addr_q;
    logic [8*BEAT_WIDTH-1:0] line_q;

    // The byte offset within the line never matters; the whole line is fetched.
    logic paddr_offset_unused;
    assign paddr_offset_unused = ^i_icache_mem_paddr[5:0];

    // Bus handshake: o_refill_bus_req is held with a stable address until the
    // cycle where req & ack are both high; a beat is taken whenever rvld is high
    // in DATA (no back-pressure toward the bus).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            drop_q <= 1'b0;
            addr_q <= '0;
            line_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_icache_mem_vld && !i_refill_flush) begin
                        addr_q <= {i_icache_mem_paddr[PADDR_WIDTH-1:6], 6'b0};
                        drop_q <= 1'b0;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (i_refill_flush) drop_q <= 1'b1;
                    if (i_bus_refill_ack) begin
                        cnt   <= 3'd0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (i_refill_flush) drop_q <= 1'b1;
                    if (i_bus_refill_rvld) begin
                        for (int k = 0; k < 8; k++) begin
                            if (cnt == 3'(k)) line_q[k*BEAT_WIDTH +: BEAT_WIDTH] <= i_bus_refill_rdat;
                        end
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) state <= RESP;
                    end
                end
                RESP: begin
                    if (i_refill_flush) drop_q <= 1'b1;
                    state <= COOL;
                end
                // COOL gives the icache write one cycle to land so the still-high
                // miss level is not mistaken for a new miss.
                COOL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_refill_bus_req   = (state == REQ);
    assign o_refill_bus_addr  = addr_q;
    assign o_mem_icache_vld   = (state == RESP) && !drop_q && !i_refill_flush;
    assign o_mem_icache_data  = line_q;
    assign o_mem_icache_paddr = addr_q;
    assign o_refill_busy      = (state != IDLE);
    assign dbg_state          = state;

endmodule

// File: tb/tb_icache_refill_module.sv
// Bench for icache_refill_module: cycle-exact bus driver, expected lines queued
// per refill and matched by an independent monitor on every line-valid pulse.
module tb_icache_refill_module;

    localparam int BW = 64;
    localparam int PW = 34;
    localparam int LW = 8 * BW;
    localparam int EW = PW + LW;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          i_icache_mem_vld = 1'b0;
    logic [PW-1:0] i_icache_mem_paddr = '0;
    logic          i_refill_flush = 1'b0;
    logic          o_refill_bus_req;
    logic [PW-1:0] o_refill_bus_addr;
    logic          i_bus_refill_ack = 1'b0;
    logic          i_bus_refill_rvld = 1'b0;
    logic [BW-1:0] i_bus_refill_rdat = '0;
    logic          o_mem_icache_vld;
    logic [LW-1:0] o_mem_icache_data;
    logic [PW-1:0] o_mem_icache_paddr;
    logic          o_refill_busy;
    logic [2:0]    dbg_state;

    icache_refill_module #(.BEAT_WIDTH(BW), .PADDR_WIDTH(PW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_icache_mem_vld   (i_icache_mem_vld),
        .i_icache_mem_paddr (i_icache_mem_paddr),
        .i_refill_flush     (i_refill_flush),
        .o_refill_bus_req   (o_refill_bus_req),
        .o_refill_bus_addr  (o_refill_bus_addr),
        .i_bus_refill_ack   (i_bus_refill_ack),
        .i_bus_refill_rvld  (i_bus_refill_rvld),
        .i_bus_refill_rdat  (i_bus_refill_rdat),
        .o_mem_icache_vld   (o_mem_icache_vld),
        .o_mem_icache_data  (o_mem_icache_data),
        .o_mem_icache_paddr (o_mem_icache_paddr),
        .o_refill_busy      (o_refill_busy),
        .dbg_state          (dbg_state)
    );

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            last_vld_cyc = -1;
    int            req_cyc = 0;
    logic          vld_prev = 1'b0;
    logic [EW-1:0] mon_e;
    int            mon_c;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_mem_icache_vld) begin
            check("vld_single_cycle", vld_prev, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vld actual=1 required=0 at cycle %0d", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("line_data", o_mem_icache_data, mon_e[LW-1:0]);
                check("line_paddr", o_mem_icache_paddr, mon_e[EW-1:LW]);
                check("vld_cycle", cyc, mon_c);
                last_vld_cyc = cyc;
            end
        end
        vld_prev <= o_mem_icache_vld;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_refill(input logic [PW-1:0] pa, input int ack_dly, input int gap_min,
                             input int gap_max, input int flush_after, input bit flush_resp,
                             input bit hold, input bit pattern);
        logic [BW-1:0] beat;
        logic [LW-1:0] line;
        logic [PW-1:0] la;
        bit dropped;
        la = pa & ~(PW'(63));
        line = '0;
        dropped = flush_resp;
        i_icache_mem_vld = 1'b1;
        i_icache_mem_paddr = pa;
        req_cyc = cyc;
        tick();
        check("req_rise", o_refill_bus_req, 1);
        check("bus_addr", o_refill_bus_addr, la);
        check("busy_in_req", o_refill_busy, 1);
        if (!hold) begin
            i_icache_mem_vld = 1'b0;
            i_icache_mem_paddr = PW'({$urandom, $urandom});
        end
        repeat (ack_dly) begin
            tick();
            check("req_held", o_refill_bus_req, 1);
            check("addr_held", o_refill_bus_addr, la);
        end
        i_bus_refill_ack = 1'b1;
        tick();
        i_bus_refill_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(gap_min, gap_max)) tick();
            beat = pattern ? 64'h1111_1111_1111_1111 * 64'(k) : {$urandom, $urandom};
            line[k*BW +: BW] = beat;
            i_bus_refill_rvld = 1'b1;
            i_bus_refill_rdat = beat;
            if (k == 7 && !dropped) begin
                exp_q.push_back({la, line});
                exp_cyc_q.push_back(cyc + 1);
            end
            tick();
            i_bus_refill_rvld = 1'b0;
            i_bus_refill_rdat = {$urandom, $urandom};
            if (k == flush_after && k < 7) begin
                i_refill_flush = 1'b1;
                dropped = 1'b1;
                tick();
                i_refill_flush = 1'b0;
            end
        end
        if (flush_resp) i_refill_flush = 1'b1;
        tick();
        i_refill_flush = 1'b0;
        check("cool_no_req", o_refill_bus_req, 0);
        check("cool_busy", o_refill_busy, 1);
        tick();
        check("idle_not_busy", o_refill_busy, 0);
        check("vld_delivered", exp_q.size(), 0);
    endtask

    initial begin
        logic [PW-1:0] pa;
        repeat (3) tick();
        check("rst_req", o_refill_bus_req, 0);
        check("rst_vld", o_mem_icache_vld, 0);
        check("rst_busy", o_refill_busy, 0);
        check("rst_data", o_mem_icache_data, 0);
        check("rst_paddr", o_mem_icache_paddr, 0);
        check("rst_bus_addr", o_refill_bus_addr, 0);
        rst_n = 1'b1;
        tick();

        // basic refill with minimum latency
        do_refill(34'h0_1234_5678, 0, 0, 0, -1, 0, 0, 1);
        check("min_latency", last_vld_cyc - req_cyc, 10);
        check("basic_paddr_out", o_mem_icache_paddr, 34'h0_1234_5640);

        // ack stall and beat gaps
        do_refill(34'h3_0000_07ff, 5, 2, 2, -1, 0, 0, 0);

        // flush mid-burst, then a normal refill
        do_refill(34'h1_aaaa_5555, 1, 0, 1, 2, 0, 0, 0);
        do_refill(34'h0_0000_0040, 0, 0, 0, -1, 0, 0, 1);

        // miss level held through RESP/COOL launches exactly one more refill
        do_refill(34'h2_4680_1357, 0, 0, 0, -1, 0, 1, 0);
        do_refill(34'h2_4680_1357, 0, 0, 1, -1, 0, 0, 0);

        // flush in the RESP cycle
        do_refill(34'h0_dead_beef, 2, 0, 1, -1, 1, 0, 0);

        // request alongside a flush in IDLE is ignored
        i_icache_mem_vld = 1'b1;
        i_refill_flush = 1'b1;
        tick();
        i_icache_mem_vld = 1'b0;
        i_refill_flush = 1'b0;
        check("flush_blocks_req", o_refill_bus_req, 0);

        // reset mid-burst with stray beats afterwards
        i_icache_mem_vld = 1'b1;
        i_icache_mem_paddr = 34'h1_1111_1111;
        tick();
        i_icache_mem_vld = 1'b0;
        i_bus_refill_ack = 1'b1;
        tick();
        i_bus_refill_ack = 1'b0;
        repeat (4) begin
            i_bus_refill_rvld = 1'b1;
            i_bus_refill_rdat = {$urandom, $urandom};
            tick();
        end
        i_bus_refill_rvld = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_req", o_refill_bus_req, 0);
        check("mid_rst_busy", o_refill_busy, 0);
        check("mid_rst_data", o_mem_icache_data, 0);
        check("mid_rst_paddr", o_mem_icache_paddr, 0);
        check("mid_rst_bus_addr", o_refill_bus_addr, 0);
        repeat (4) begin
            i_bus_refill_rvld = 1'b1;
            i_bus_refill_rdat = {$urandom, $urandom};
            tick();
            check("stray_beat_busy", o_refill_busy, 0);
            check("stray_beat_vld", o_mem_icache_vld, 0);
        end
        i_bus_refill_rvld = 1'b0;
        do_refill(34'h0_1234_5678, 0, 0, 0, -1, 0, 0, 1);

        // randomized refills
        for (int n = 0; n < 16; n++) begin
            int fa;
            bit fr;
            pa = PW'({$urandom, $urandom});
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            fr = (fa < 0) && ($urandom_range(0, 5) == 0);
            do_refill(pa, $urandom_range(0, 4), 0, $urandom_range(0, 3), fa, fr, 0, 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (4) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
